// File: rtl/uf_label_sched_if.sv
// Signal bundle between the labeller/engine side (master) and the merge scheduler (slave).
// Merge channel: a pair transfers on any rising clk edge where mrg_valid && mrg_ready;
// the master holds mrg_valid/mrg_a/mrg_b stable until that edge, and mrg_ready may drop at any time.
interface uf_label_sched_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 9
);
  logic                  mrg_valid;
  logic                  mrg_ready;
  logic [ADDR_WIDTH-1:0] mrg_a;
  logic [ADDR_WIDTH-1:0] mrg_b;
  logic                  frame_end;
  logic [ADDR_WIDTH:0]   label_cnt;
  logic [1:0]            uf_op;
  logic [ADDR_WIDTH-1:0] uf_node1;
  logic [ADDR_WIDTH-1:0] uf_node2;
  logic [ADDR_WIDTH-1:0] uf_result;
  logic                  uf_done;
  logic                  uf_idle;
  logic                  lut_we;
  logic [ADDR_WIDTH-1:0] lut_addr;
  logic [ADDR_WIDTH-1:0] lut_data;
  logic [CNT_WIDTH-1:0]  comp_cnt;
  logic                  resolve_done;
  logic                  busy;
  logic                  ovf;
  logic [2:0]            dbg_state;

  modport slave (
    input  mrg_valid, mrg_a, mrg_b, frame_end, label_cnt, uf_result, uf_done, uf_idle,
    output mrg_ready, uf_op, uf_node1, uf_node2, lut_we, lut_addr, lut_data,
           comp_cnt, resolve_done, busy, ovf, dbg_state
  );

  modport master (
    output mrg_valid, mrg_a, mrg_b, frame_end, label_cnt, uf_result, uf_done, uf_idle,
    input  mrg_ready, uf_op, uf_node1, uf_node2, lut_we, lut_addr, lut_data,
           comp_cnt, resolve_done, busy, ovf, dbg_state
  );
endinterface

// File: rtl/uf_label_sched.sv
// Merge-request scheduler: buffers label merges, feeds them to the union-find engine,
// then resolves every label to its root into the remap LUT and counts components.
module uf_label_sched #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 9
) (
  input  logic           clk,
  input  logic           reset_n,
  uf_label_sched_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] MAX_LABELS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [1:0] OP_UNION = 2'b01;
  localparam logic [1:0] OP_FIND  = 2'b10;

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_UWAIT = 3'd1,
    S_DRAIN = 3'd2,
    S_FIND  = 3'd3,
    S_FWAIT = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t state;
  state_t ret_state;

  logic [2*ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW:0]             count;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    fe_acc;
  logic [ADDR_WIDTH-1:0]   head_a;
  logic [ADDR_WIDTH-1:0]   head_b;
  logic [ADDR_WIDTH:0]     lcnt;
  logic [ADDR_WIDTH:0]     lcnt_clamp;
  logic [ADDR_WIDTH-1:0]   idx;

  logic [1:0]              uf_op_q;
  logic [ADDR_WIDTH-1:0]   node1_q;
  logic [ADDR_WIDTH-1:0]   node2_q;
  logic                    lut_we_q;
  logic [ADDR_WIDTH-1:0]   lut_addr_q;
  logic [ADDR_WIDTH-1:0]   lut_data_q;
  logic [CNT_WIDTH-1:0]    comp_q;
  logic                    rdone_q;
  logic                    busy_q;
  logic                    ovf_q;

  assign full   = (count == (PW+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign fe_acc = bus.frame_end && (state == S_RUN);

  assign bus.mrg_ready = !full && !busy_q;
  // Self-merges carry no equivalence information, so they are swallowed here.
  assign push = bus.mrg_valid && bus.mrg_ready && (bus.mrg_a != bus.mrg_b);
  // frame_end wins over an issue in S_RUN so the drain sees every queued pair.
  assign pop  = !empty && bus.uf_idle &&
                (((state == S_RUN) && !bus.frame_end) || (state == S_DRAIN));

  assign {head_a, head_b} = mem[rd_ptr];
  assign lcnt_clamp = (bus.label_cnt > MAX_LABELS) ? MAX_LABELS : bus.label_cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.mrg_a, bus.mrg_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Overflow is sticky for the frame; the next accepted frame_end starts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (fe_acc) begin
      ovf_q <= 1'b0;
    end else if (bus.mrg_valid && full && !busy_q) begin
      ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_RUN;
      ret_state  <= S_RUN;
      lcnt       <= '0;
      idx        <= '0;
      uf_op_q    <= 2'b00;
      node1_q    <= '0;
      node2_q    <= '0;
      lut_we_q   <= 1'b0;
      lut_addr_q <= '0;
      lut_data_q <= '0;
      comp_q     <= '0;
      rdone_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      uf_op_q  <= 2'b00;
      lut_we_q <= 1'b0;
      rdone_q  <= 1'b0;
      case (state)
        S_RUN: begin
          if (fe_acc) begin
            lcnt   <= lcnt_clamp;
            busy_q <= 1'b1;
            comp_q <= '0;
            state  <= S_DRAIN;
          end else if (pop) begin
            uf_op_q   <= OP_UNION;
            node1_q   <= head_a;
            node2_q   <= head_b;
            ret_state <= S_RUN;
            state     <= S_UWAIT;
          end
        end
        S_UWAIT: begin
          if (bus.uf_done) state <= ret_state;
        end
        S_DRAIN: begin
          if (pop) begin
            uf_op_q   <= OP_UNION;
            node1_q   <= head_a;
            node2_q   <= head_b;
            ret_state <= S_DRAIN;
            state     <= S_UWAIT;
          end else if (empty) begin
            idx    <= '0;
            comp_q <= '0;
            state  <= (lcnt == '0) ? S_FIN : S_FIND;
          end
        end
        S_FIND: begin
          if (bus.uf_idle) begin
            uf_op_q <= OP_FIND;
            node1_q <= idx;
            node2_q <= '0;
            state   <= S_FWAIT;
          end
        end
        S_FWAIT: begin
          if (bus.uf_done) begin
            lut_we_q   <= 1'b1;
            lut_addr_q <= idx;
            lut_data_q <= bus.uf_result;
            if (bus.uf_result == idx) comp_q <= comp_q + CNT_WIDTH'(1);
            // Stop on the last label rather than after it so idx never wraps.
            if ({1'b0, idx} == lcnt - (ADDR_WIDTH+1)'(1)) begin
              state <= S_FIN;
            end else begin
              idx   <= idx + ADDR_WIDTH'(1);
              state <= S_FIND;
            end
          end
        end
        S_FIN: begin
          rdone_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign bus.uf_op        = uf_op_q;
  assign bus.uf_node1     = node1_q;
  assign bus.uf_node2     = node2_q;
  assign bus.lut_we       = lut_we_q;
  assign bus.lut_addr     = lut_addr_q;
  assign bus.lut_data     = lut_data_q;
  assign bus.comp_cnt     = comp_q;
  assign bus.resolve_done = rdone_q;
  assign bus.busy         = busy_q;
  assign bus.ovf          = ovf_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_uf_label_sched.sv
// Directed bench for uf_label_sched: a table of frames with hand-computed roots,
// plus sequences for FIFO overflow, empty label set and reset during a FIND.
module tb_uf_label_sched;
  localparam int AW = 8;
  localparam int CW = 9;

  typedef logic [3:0][7:0] l4_t;
  typedef logic [7:0][7:0] l8_t;
  typedef struct packed {
    int         n;
    l4_t        a;
    l4_t        b;
    logic [8:0] lc;
    int         exp_unions;
    int         exp_finds;
    logic [8:0] exp_comp;
    l8_t        root;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uf_label_sched_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  uf_label_sched #(.ADDR_WIDTH(AW), .FIFO_DEPTH(16), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Union-find engine model: union links root(node2) under root(node1).
  logic [7:0] parent [256];
  logic       eng_busy;
  logic [1:0] eng_lat;
  logic [7:0] eng_res;
  logic       eng_clr = 1'b0;
  logic       stall = 1'b0;

  function automatic logic [7:0] find_root(input logic [7:0] n);
    logic [7:0] r = n;
    for (int k = 0; k < 256; k++) if (parent[r] != r) r = parent[r];
    return r;
  endfunction

  assign bus.uf_idle = !eng_busy && !stall;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_busy      <= 1'b0;
      eng_lat       <= 2'd0;
      eng_res       <= 8'd0;
      bus.uf_done   <= 1'b0;
      bus.uf_result <= 8'd0;
    end else begin
      bus.uf_done <= 1'b0;
      if (eng_clr) begin
        for (int i = 0; i < 256; i++) parent[i] = i[7:0];
      end else if (eng_busy) begin
        if (eng_lat == 2'd0) begin
          bus.uf_done   <= 1'b1;
          bus.uf_result <= eng_res;
          eng_busy      <= 1'b0;
        end else begin
          eng_lat <= eng_lat - 2'd1;
        end
      end else if (bus.uf_op == 2'b01) begin
        parent[find_root(bus.uf_node2)] = find_root(bus.uf_node1);
        eng_busy <= 1'b1;
        eng_lat  <= 2'd2;
      end else if (bus.uf_op == 2'b10) begin
        eng_res  <= find_root(bus.uf_node1);
        eng_busy <= 1'b1;
        eng_lat  <= 2'd2;
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int unions, finds, lutw, rdone, viol;
  logic [1:0] prev_op;
  logic [7:0] got_root [8];
  logic [7:0] lut_bad;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sample();
    if (bus.uf_op != 2'b00) begin
      if (prev_op != 2'b00 || !bus.uf_idle || bus.uf_done) viol++;
      if (bus.uf_op == 2'b01) unions++;
      else if (bus.uf_op == 2'b10) finds++;
      else viol++;
    end
    prev_op = bus.uf_op;
    if (bus.mrg_ready && bus.busy) viol++;
    if (bus.lut_we) begin
      lutw++;
      if (bus.lut_addr < 8) got_root[bus.lut_addr[2:0]] = bus.lut_data;
    end
    if (bus.resolve_done) rdone++;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    sample();
  endtask

  task automatic stats_reset();
    unions = 0; finds = 0; lutw = 0; rdone = 0;
    for (int i = 0; i < 8; i++) got_root[i] = 8'hEE;
  endtask

  task automatic eng_clear();
    eng_clr = 1'b1;
    cyc();
    eng_clr = 1'b0;
  endtask

  task automatic pulse_frame_end(input string tag, input logic [8:0] lc);
    int k = 0;
    while (bus.dbg_state != 3'd0 && k < 200) begin cyc(); k++; end
    chk({tag, " run-state timeout"}, 32'(k < 200), 32'd1);
    bus.frame_end = 1'b1;
    bus.label_cnt = lc;
    cyc();
    bus.frame_end = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (rdone == 0 && k < 5000) begin cyc(); k++; end
    chk({tag, " resolve timeout"}, 32'(k < 5000), 32'd1);
    repeat (3) cyc();
  endtask

  task automatic run_frame(input int vi);
    vec_t v = vecs[vi];
    string tag = $sformatf("v%0d", vi);
    int nchk;
    eng_clear();
    stats_reset();
    for (int i = 0; i < v.n; i++) begin
      int k = 0;
      bus.mrg_valid = 1'b1;
      bus.mrg_a = v.a[i];
      bus.mrg_b = v.b[i];
      while (!bus.mrg_ready && k < 200) begin cyc(); k++; end
      cyc();
    end
    bus.mrg_valid = 1'b0;
    pulse_frame_end(tag, v.lc);
    wait_done(tag);
    chk({tag, " comp_cnt"}, 32'(bus.comp_cnt), 32'(v.exp_comp));
    chk({tag, " union ops"}, 32'(unions), 32'(v.exp_unions));
    chk({tag, " find ops"}, 32'(finds), 32'(v.exp_finds));
    chk({tag, " lut writes"}, 32'(lutw), 32'(v.exp_finds));
    chk({tag, " resolve_done pulses"}, 32'(rdone), 32'd1);
    chk({tag, " busy after"}, 32'(bus.busy), 32'd0);
    nchk = (v.exp_finds < 8) ? v.exp_finds : 8;
    for (int i = 0; i < nchk; i++)
      chk($sformatf("%s lut[%0d]", tag, i), 32'(got_root[i]), 32'(v.root[i]));
  endtask

  function automatic l4_t l4(input logic [7:0] x0, x1, x2, x3);
    l4_t r;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
    return r;
  endfunction

  function automatic l8_t l8(input logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7);
    l8_t r;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
    r[4] = x4; r[5] = x5; r[6] = x6; r[7] = x7;
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, " mrg_ready"}, 32'(bus.mrg_ready), 32'd1);
    chk({tag, " uf_op"}, 32'(bus.uf_op), 32'd0);
    chk({tag, " lut_we"}, 32'(bus.lut_we), 32'd0);
    chk({tag, " comp_cnt"}, 32'(bus.comp_cnt), 32'd0);
    chk({tag, " resolve_done"}, 32'(bus.resolve_done), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " ovf"}, 32'(bus.ovf), 32'd0);
    chk({tag, " state"}, 32'(bus.dbg_state), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;
    vecs[0] = '{n:3, a:l4(1,3,2,0), b:l4(2,4,3,0), lc:9'd6, exp_unions:3, exp_finds:6,
                exp_comp:9'd3, root:l8(0,1,1,1,1,5,0,0)};
    vecs[1] = '{n:1, a:l4(7,0,0,0), b:l4(7,0,0,0), lc:9'd8, exp_unions:0, exp_finds:8,
                exp_comp:9'd8, root:l8(0,1,2,3,4,5,6,7)};
    vecs[2] = '{n:4, a:l4(0,2,4,6), b:l4(1,3,5,7), lc:9'd8, exp_unions:4, exp_finds:8,
                exp_comp:9'd4, root:l8(0,0,2,2,4,4,6,6)};
    vecs[3] = '{n:3, a:l4(5,5,3,0), b:l4(0,3,5,0), lc:9'd6, exp_unions:3, exp_finds:6,
                exp_comp:9'd4, root:l8(5,1,2,5,4,5,0,0)};
    vecs[4] = '{n:1, a:l4(1,0,0,0), b:l4(0,0,0,0), lc:9'd2, exp_unions:1, exp_finds:2,
                exp_comp:9'd1, root:l8(1,1,0,0,0,0,0,0)};
    vecs[5] = '{n:0, a:l4(0,0,0,0), b:l4(0,0,0,0), lc:9'h1FF, exp_unions:0, exp_finds:256,
                exp_comp:9'd256, root:l8(0,1,2,3,4,5,6,7)};
    vecs[6] = '{n:1, a:l4(0,0,0,0), b:l4(1,0,0,0), lc:9'd2, exp_unions:1, exp_finds:2,
                exp_comp:9'd1, root:l8(0,0,0,0,0,0,0,0)};

    bus.mrg_valid = 1'b0;
    bus.mrg_a     = 8'd0;
    bus.mrg_b     = 8'd0;
    bus.frame_end = 1'b0;
    bus.label_cnt = 9'd0;
    prev_op = 2'b00;
    viol = 0;
    stats_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    cyc();

    for (int vi = 0; vi < 6; vi++) run_frame(vi);

    // FIFO fill with the engine stalled, then drain into an empty label set.
    eng_clear();
    stats_reset();
    stall = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      bus.mrg_valid = 1'b1;
      bus.mrg_a = 8'(16 + i);
      bus.mrg_b = 8'(40 + i);
      if (i == 16) begin
        chk("fill mrg_ready at full", 32'(bus.mrg_ready), 32'd0);
        chk("fill ovf before held valid", 32'(bus.ovf), 32'd0);
      end
      if (bus.mrg_ready) acc++;
      cyc();
    end
    chk("fill accepts", 32'(acc), 32'd16);
    chk("fill ovf after held valid", 32'(bus.ovf), 32'd1);
    chk("fill no ops while stalled", 32'(unions), 32'd0);
    bus.mrg_valid = 1'b0;
    stall = 1'b0;
    pulse_frame_end("drain", 9'd0);
    chk("drain ovf cleared", 32'(bus.ovf), 32'd0);
    wait_done("drain");
    chk("drain union ops", 32'(unions), 32'd16);
    chk("drain find ops", 32'(finds), 32'd0);
    chk("drain lut writes", 32'(lutw), 32'd0);
    chk("drain comp_cnt", 32'(bus.comp_cnt), 32'd0);
    chk("drain resolve_done pulses", 32'(rdone), 32'd1);

    // Reset while a FIND is outstanding.
    eng_clear();
    stats_reset();
    pulse_frame_end("midreset", 9'd4);
    k = 0;
    while (bus.dbg_state != 3'd4 && k < 100) begin cyc(); k++; end
    chk("midreset reach fwait", 32'(k < 100), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    prev_op = 2'b00;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    run_frame(6);

    chk("op protocol violations", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
